// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, data width and bit-period helper.
package uart_pkg;

   localparam int unsigned UartDataWidth = 8;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK
   } uart_rx_state_e;

   // System clocks per serial bit, rounded down; the TX block uses the same rule.
   function automatic int unsigned clocks_per_bit(input int unsigned clock_frequency,
                                                  input int unsigned baud_rate);
      return clock_frequency / baud_rate;
   endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Small first-word fall-through FIFO holding received bytes.
module uart_rx_fifo #(
   parameter int unsigned Width = 8,
   parameter int unsigned Depth = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     push_i,
   input  logic [Width-1:0]         wdata_i,
   input  logic                     pop_i,
   output logic [Width-1:0]         rdata_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(Depth):0]   level_o
);

   localparam int unsigned PtrW = $clog2(Depth);
   localparam int unsigned LvlW = PtrW + 1;

   if (Depth < 2 || (Depth & (Depth - 1)) != 0) begin : gen_depth_err
      $error("uart_rx_fifo: Depth must be a power of two and at least 2");
   end

   logic [Width-1:0] mem_q [Depth];
   logic [Width-1:0] mem_d [Depth];
   logic [PtrW-1:0]  wptr_q, wptr_d;
   logic [PtrW-1:0]  rptr_q, rptr_d;
   logic [LvlW-1:0]  level_q, level_d;
   logic             do_push, do_pop;

   assign empty_o = (level_q == '0);
   assign full_o  = (level_q == LvlW'(Depth));
   assign level_o = level_q;
   assign rdata_o = mem_q[rptr_q];

   // Pop is evaluated first, so a push into a full FIFO succeeds when it is popped that cycle.
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   // Next-state for storage, pointers (wrap naturally on power-of-two depth) and occupancy.
   always_comb begin
      mem_d   = mem_q;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      level_d = level_q;
      if (do_push) begin
         mem_d[wptr_q] = wdata_i;
         wptr_d        = wptr_q + PtrW'(1);
      end
      if (do_pop) begin
         rptr_d = rptr_q + PtrW'(1);
      end
      level_d = level_q + LvlW'(do_push) - LvlW'(do_pop);
   end

   // FIFO state registers; storage cleared so the head reads zero out of reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < int'(Depth); i++) begin
            mem_q[i] <= '0;
         end
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
      end else begin
         mem_q   <= mem_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         level_q <= level_d;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchroniser, mid-bit sampling FSM and receive FIFO.
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned ClockFrequency = 50_000_000,
   parameter int unsigned BaudRate       = 115_200,
   parameter int unsigned FifoDepth      = 4
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic                           rx_i,
   output logic [UartDataWidth-1:0]       rx_data_o,
   output logic                           rx_valid_o,
   input  logic                           rx_ready_i,
   output logic [$clog2(FifoDepth):0]     rx_level_o,
   output logic                           rx_busy_o,
   output logic                           frame_err_o,
   output logic                           overrun_o
);

   localparam int unsigned ClocksPerBit = clocks_per_bit(ClockFrequency, BaudRate);
   localparam int unsigned HalfBit      = ClocksPerBit / 2;
   localparam int unsigned TimerW       = $clog2(ClocksPerBit);
   localparam logic [TimerW-1:0] HalfLoad = TimerW'(HalfBit - 1);
   localparam logic [TimerW-1:0] BitLoad  = TimerW'(ClocksPerBit - 1);
   localparam logic [2:0]        LastBit  = 3'(UartDataWidth - 1);

   if (ClocksPerBit < 4) begin : gen_cpb_err
      $error("uart_rx: ClocksPerBit must be at least 4");
   end

   logic                     sync1_q, sync2_q, rx_prev_q;
   logic                     rx_s, fall;
   uart_rx_state_e           state_q, state_d;
   logic [TimerW-1:0]        timer_q, timer_d;
   logic [2:0]               bit_idx_q, bit_idx_d;
   logic [UartDataWidth-1:0] shift_q, shift_d;
   logic                     frame_err_q, frame_err_d;
   logic                     overrun_q, overrun_d;
   logic                     expired, push, pop, fifo_full, fifo_empty;

   assign rx_s    = sync2_q;
   assign fall    = !rx_s && rx_prev_q;
   assign expired = (timer_q == '0);
   assign pop     = rx_valid_o && rx_ready_i;

   assign rx_valid_o  = !fifo_empty;
   assign rx_busy_o   = (state_q != IDLE);
   assign frame_err_o = frame_err_q;
   assign overrun_o   = overrun_q;

   // Two-flop synchroniser plus a delayed copy for falling-edge detection; idle level is high.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q   <= 1'b1;
         sync2_q   <= 1'b1;
         rx_prev_q <= 1'b1;
      end else begin
         sync1_q   <= rx_i;
         sync2_q   <= sync1_q;
         rx_prev_q <= sync2_q;
      end
   end

   // Frame decoding: next state, bit timer, shift register and error pulses.
   always_comb begin
      state_d     = state_q;
      timer_d     = expired ? timer_q : timer_q - TimerW'(1);
      bit_idx_d   = bit_idx_q;
      shift_d     = shift_q;
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;
      push        = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (fall) begin
               timer_d = HalfLoad;
               state_d = START;
            end
         end
         START: begin
            if (expired) begin
               if (rx_s) begin
                  // Line went back high before mid-start-bit: treat as a glitch.
                  state_d = IDLE;
               end else begin
                  timer_d   = BitLoad;
                  bit_idx_d = '0;
                  state_d   = DATA;
               end
            end
         end
         DATA: begin
            if (expired) begin
               shift_d = {rx_s, shift_q[UartDataWidth-1:1]};
               timer_d = BitLoad;
               if (bit_idx_q == LastBit) begin
                  state_d = STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end
         end
         STOP: begin
            if (expired) begin
               if (rx_s) begin
                  if (!fifo_full || pop) begin
                     push = 1'b1;
                  end else begin
                     overrun_d = 1'b1;
                  end
                  state_d = IDLE;
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = BREAK;
               end
            end
         end
         BREAK: begin
            // Hold off until the line returns high so a long break is reported only once.
            if (rx_s) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Receiver FSM registers and registered error pulses.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         timer_q     <= '0;
         bit_idx_q   <= '0;
         shift_q     <= '0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         bit_idx_q   <= bit_idx_d;
         shift_q     <= shift_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
      end
   end

   uart_rx_fifo #(
      .Width (UartDataWidth),
      .Depth (FifoDepth)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (push),
      .wdata_i (shift_q),
      .pop_i   (pop),
      .rdata_o (rx_data_o),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .level_o (rx_level_o)
   );

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed vectors, corner sequences and random traffic
// checked against a cycle-level queue model of the receive path.
module tb_uart_rx;

   localparam int unsigned ClockFrequency = 1_600_000;
   localparam int unsigned BaudRate       = 100_000;
   localparam int unsigned FifoDepth      = 4;
   localparam int unsigned Cpb            = 16;
   // Stop bit is sampled HalfBit + 9 bit periods + 2 sync cycles after the line falls.
   localparam int unsigned StopLat        = 2 + Cpb / 2 + 9 * Cpb;

   logic       clk;
   logic       rst_n;
   logic       rx_line;
   logic       rx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic [2:0] rx_level;
   logic       rx_busy;
   logic       frame_err;
   logic       overrun;

   uart_rx #(
      .ClockFrequency (ClockFrequency),
      .BaudRate       (BaudRate),
      .FifoDepth      (FifoDepth)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .rx_i        (rx_line),
      .rx_data_o   (rx_data),
      .rx_valid_o  (rx_valid),
      .rx_ready_i  (rx_ready),
      .rx_level_o  (rx_level),
      .rx_busy_o   (rx_busy),
      .frame_err_o (frame_err),
      .overrun_o   (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int unsigned checks = 0;
   int unsigned passes = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // ---------------- observation of DUT outputs (mid-cycle) ----------------
   typedef struct {
      logic [7:0]  data;
      int unsigned cyc;
   } pop_t;
   pop_t        act_q[$];
   int unsigned fe_cnt = 0, ov_cnt = 0, ov_cyc = 0, both_cnt = 0;

   // ---------------- reference model: byte queue of capacity FifoDepth ----------------
   typedef struct {
      int unsigned cyc;
      logic [7:0]  data;
   } ev_t;
   ev_t         pend_q[$];
   logic [7:0]  mq[$];
   bit          model_en = 1'b1;
   int unsigned exp_ov = 0, model_pops = 0, model_errs = 0;
   int unsigned exp_lvl;
   logic [7:0]  exp_head;

   always @(posedge clk) begin
      if (!rst_n) begin
         mq.delete();
         pend_q.delete();
      end else if (model_en) begin
         if (mq.size() != 0 && rx_ready) begin
            void'(mq.pop_front());
            model_pops++;
         end
         if (pend_q.size() != 0 && pend_q[0].cyc == cyc) begin
            if (mq.size() < FifoDepth) mq.push_back(pend_q[0].data);
            else exp_ov++;
            void'(pend_q.pop_front());
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         if (rx_valid && rx_ready) act_q.push_back('{data: rx_data, cyc: cyc});
         if (frame_err) fe_cnt++;
         if (overrun) begin
            ov_cnt++;
            ov_cyc = cyc;
         end
         if (frame_err && overrun) both_cnt++;
         if (model_en) begin
            exp_lvl  = mq.size();
            exp_head = (exp_lvl != 0) ? mq[0] : 8'h00;
            if (rx_level !== 3'(exp_lvl) || rx_valid !== (exp_lvl != 0) ||
                (exp_lvl != 0 && rx_data !== exp_head)) begin
               model_errs++;
               if (model_errs <= 8)
                  $display("FAIL model_track cyc=%0d: level %0d valid %0b data 0x%0h, expected level %0d valid %0b data 0x%0h",
                           cyc, rx_level, rx_valid, rx_data, exp_lvl, exp_lvl != 0, exp_head);
            end
         end
      end
   end

   // ---------------- stimulus helpers (each ends 1 time unit after a rising edge) ----------------
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drive_cycles(input logic v, input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1 rx_line = v;
      end
   endtask

   // One 8N1 frame, 16 clocks per bit; fall returns the cycle the start bit was driven.
   task automatic send_frame(input logic [7:0] d, input bit stop_ok, output int unsigned fall);
      logic [9:0] bits;
      bits = {stop_ok, d, 1'b0};
      @(posedge clk);
      #1 rx_line = 1'b0;
      fall = cyc;
      if (stop_ok && model_en) pend_q.push_back('{cyc: fall + StopLat, data: d});
      drive_cycles(1'b0, Cpb - 1);
      for (int i = 1; i < 10; i++) drive_cycles(bits[i], Cpb);
   endtask

   typedef struct {
      logic [7:0]  data;
      bit          stop_ok;
      int unsigned exp_bytes;
      int unsigned exp_fe;
   } vec_t;
   vec_t vecs[6];

   int unsigned f, f5, base, fe0, ov0, pops0, bad;
   bit          rand_done;
   logic [7:0]  rd;
   bit          rs;

   initial begin
      vecs[0] = '{8'h00, 1'b1, 1, 0};
      vecs[1] = '{8'hFF, 1'b1, 1, 0};
      vecs[2] = '{8'h80, 1'b1, 1, 0};
      vecs[3] = '{8'h5A, 1'b0, 0, 1};
      vecs[4] = '{8'h01, 1'b1, 1, 0};
      vecs[5] = '{8'hC7, 1'b0, 0, 1};

      rst_n = 1'b0; rx_line = 1'b1; rx_ready = 1'b0;
      step(3);
      @(negedge clk);
      chk("reset_data", rx_data, 8'h00);
      chk("reset_valid", rx_valid, 1'b0);
      chk("reset_level", rx_level, 3'd0);
      chk("reset_busy", rx_busy, 1'b0);
      chk("reset_frame_err", frame_err, 1'b0);
      chk("reset_overrun", overrun, 1'b0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      step(5);

      // Single byte with exact latency from the line fall.
      rx_ready = 1'b1;
      base = act_q.size(); fe0 = fe_cnt; ov0 = ov_cnt;
      send_frame(8'hA5, 1'b1, f);
      drive_cycles(1'b1, 20);
      chk("single_count", act_q.size() - base, 1);
      if (act_q.size() > base) begin
         chk("single_data", act_q[base].data, 8'hA5);
         chk("single_latency", act_q[base].cyc - f, 2 + 8 + 144 + 1);
      end
      chk("single_no_fe", fe_cnt - fe0, 0);
      chk("single_no_ov", ov_cnt - ov0, 0);

      // Five-cycle low glitch: start check rejects it.
      base = act_q.size(); fe0 = fe_cnt;
      @(posedge clk);
      #1 rx_line = 1'b0;
      drive_cycles(1'b0, 4);
      drive_cycles(1'b1, 1);
      @(negedge clk);
      chk("glitch_busy_during", rx_busy, 1'b1);
      step(15);
      @(negedge clk);
      chk("glitch_busy_after", rx_busy, 1'b0);
      chk("glitch_no_byte", act_q.size() - base, 0);
      chk("glitch_no_fe", fe_cnt - fe0, 0);

      // Table of single frames.
      foreach (vecs[i]) begin
         base = act_q.size(); fe0 = fe_cnt;
         send_frame(vecs[i].data, vecs[i].stop_ok, f);
         drive_cycles(1'b1, 30);
         chk($sformatf("vec%0d_bytes", i), act_q.size() - base, vecs[i].exp_bytes);
         chk($sformatf("vec%0d_fe", i), fe_cnt - fe0, vecs[i].exp_fe);
         if (vecs[i].exp_bytes != 0 && act_q.size() > base)
            chk($sformatf("vec%0d_data", i), act_q[base].data, vecs[i].data);
      end

      // Bad stop, line held low (break), then a good frame.
      base = act_q.size(); fe0 = fe_cnt;
      send_frame(8'h3C, 1'b0, f);
      drive_cycles(1'b0, 40);
      @(negedge clk);
      chk("break_busy", rx_busy, 1'b1);
      drive_cycles(1'b1, 16);
      send_frame(8'h55, 1'b1, f);
      drive_cycles(1'b1, 20);
      chk("break_fe_once", fe_cnt - fe0, 1);
      chk("break_bytes", act_q.size() - base, 1);
      if (act_q.size() > base) chk("break_data", act_q[base].data, 8'h55);

      // Overrun: five back-to-back bytes into a 4-deep FIFO with no consumer.
      rx_ready = 1'b0;
      ov0 = ov_cnt;
      for (int b = 1; b <= 5; b++) send_frame(8'(b), 1'b1, f5);
      drive_cycles(1'b1, 4);
      @(negedge clk);
      chk("ovr_level", rx_level, 3'd4);
      chk("ovr_count", ov_cnt - ov0, 1);
      chk("ovr_cycle", ov_cyc - f5, StopLat + 1);
      @(posedge clk);
      #1 rx_ready = 1'b1;
      base = act_q.size();
      step(8);
      chk("ovr_drain_count", act_q.size() - base, 4);
      for (int k = 0; k < 4; k++)
         if (act_q.size() > base + k)
            chk($sformatf("ovr_drain%0d", k), act_q[base + k].data, 8'(k + 1));

      // Full FIFO with a pop on the exact cycle of the stop-bit push.
      rx_ready = 1'b0;
      for (int b = 0; b < 4; b++) send_frame(8'h11 + 8'(b), 1'b1, f);
      drive_cycles(1'b1, 5);
      base = act_q.size(); ov0 = ov_cnt;
      fork
         send_frame(8'h99, 1'b1, f);
         begin
            step(StopLat + 1);
            rx_ready = 1'b1;
            step(1);
            rx_ready = 1'b0;
         end
      join
      @(negedge clk);
      chk("pp_level", rx_level, 3'd4);
      chk("pp_no_ovr", ov_cnt - ov0, 0);
      chk("pp_one_pop", act_q.size() - base, 1);
      chk("pp_head", rx_data, 8'h12);
      @(posedge clk);
      #1 rx_ready = 1'b1;
      base = act_q.size();
      step(8);
      chk("pp_drain_count", act_q.size() - base, 4);
      if (act_q.size() >= base + 4) begin
         chk("pp_drain0", act_q[base].data, 8'h12);
         chk("pp_drain3", act_q[base + 3].data, 8'h99);
      end

      // Random traffic with random consumer back-pressure, checked by the model.
      base = act_q.size(); fe0 = fe_cnt; pops0 = model_pops; bad = 0; rand_done = 1'b0;
      fork
         begin
            for (int k = 0; k < 24; k++) begin
               rd = 8'($urandom);
               rs = ($urandom_range(0, 5) != 0);
               send_frame(rd, rs, f);
               if (!rs) begin
                  bad++;
                  drive_cycles(1'b1, $urandom_range(2, 12));
               end else if ($urandom_range(0, 1) != 0) begin
                  drive_cycles(1'b1, $urandom_range(1, 6));
               end
            end
            rand_done = 1'b1;
         end
         begin
            while (!rand_done) begin
               @(posedge clk);
               #1 rx_ready = ($urandom_range(0, 2) != 0);
            end
         end
      join
      rx_ready = 1'b1;
      drive_cycles(1'b1, 40);
      chk("rand_fe", fe_cnt - fe0, bad);
      chk("rand_pops", act_q.size() - base, model_pops - pops0);
      chk("rand_drained", rx_level, 3'd0);

      // Reset in the middle of data bit 4 with a byte already buffered.
      rx_ready = 1'b0;
      send_frame(8'h42, 1'b1, f);
      drive_cycles(1'b1, 10);
      fork
         send_frame(8'hC3, 1'b1, f);
         begin
            step(2 + 8 + 16 * 5 - 5 + 1);
            model_en = 1'b0;
            #2 rst_n = 1'b0;
            #1;
            chk("rst_mid_valid", rx_valid, 1'b0);
            chk("rst_mid_level", rx_level, 3'd0);
            chk("rst_mid_data", rx_data, 8'h00);
            chk("rst_mid_busy", rx_busy, 1'b0);
            chk("rst_mid_fe", frame_err, 1'b0);
            chk("rst_mid_ov", overrun, 1'b0);
            step(3);
            rst_n = 1'b1;
         end
      join
      rx_ready = 1'b1;
      drive_cycles(1'b1, 300);
      @(negedge clk);
      chk("rst_resync_empty", rx_level, 3'd0);
      model_en = 1'b1;
      base = act_q.size();
      send_frame(8'h7E, 1'b1, f);
      drive_cycles(1'b1, 20);
      chk("rst_after_count", act_q.size() - base, 1);
      if (act_q.size() > base) chk("rst_after_data", act_q[base].data, 8'h7E);

      chk("model_tracking", model_errs, 0);
      chk("overrun_total", ov_cnt, exp_ov);
      chk("fe_ov_exclusive", both_cnt, 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver for the Ibex demo system; the receive-side counterpart of the system's UART transmitter.
- Samples the board-level RX pin and recovers bytes by mid-bit sampling from a clock-divided bit timer.
- Buffers received bytes in a small FIFO with a valid/ready output, for the bus-facing UART register block to drain.
- Reports framing errors and overruns as single-cycle pulses.

Parameters:
- ClockFrequency, 50_000_000, system clock frequency in Hz.
- BaudRate, 115_200, line rate in bit/s. ClocksPerBit = ClockFrequency / BaudRate (integer floor). Elaboration error if ClocksPerBit < 4.
- FifoDepth, 4, receive FIFO entries. Power of two, minimum 2.

Ports:
- clk_i  input  1  system clock.
- rst_ni  input  1  reset. One clock; reset is asynchronous and active-low.
- rx_i  input  1  asynchronous serial input, idle high.
- rx_data_o  output  8  byte at FIFO head. Reset value 0.
- rx_valid_o  output  1  FIFO non-empty. Reset value 0.
- rx_ready_i  input  1  consumer pops the head when rx_valid_o && rx_ready_i.
- rx_level_o  output  $clog2(FifoDepth)+1  FIFO occupancy. Reset value 0.
- rx_busy_o  output  1  FSM not in IDLE. Reset value 0.
- frame_err_o  output  1  one-cycle pulse on a bad stop bit. Reset value 0.
- overrun_o  output  1  one-cycle pulse when a good byte is dropped because the FIFO is full. Reset value 0.

Behaviour:
- Synchroniser: rx_i passes through a 2-flop synchroniser, both flops reset to 1, giving rx_s. A falling edge is rx_s==0 while the registered previous rx_s==1.
- Bit timer: down-counter, width $clog2(ClocksPerBit). HalfBit = ClocksPerBit/2.
- IDLE: on a falling edge, load the timer with HalfBit-1 and go to START.
- START: when the timer reaches 0, sample rx_s.
  - rx_s==1: false start; go to IDLE with no error.
  - rx_s==0: load the timer with ClocksPerBit-1, clear the bit index, go to DATA.
- DATA: each time the timer expires, sample rx_s into the shift register LSB-first and reload the timer.
  - After bit index 7, go to STOP.
- STOP: when the timer expires, sample rx_s.
  - rx_s==1: push the byte if the FIFO is not full. If it is full, drop the byte and pulse overrun_o. Go to IDLE.
  - rx_s==0: pulse frame_err_o, discard the byte, go to BREAK.
- BREAK: wait until rx_s==1 (a held-low line or break does not retrigger), then go to IDLE.
- Timing, with falling edge seen at cycle t:
  - Start bit checked at t+HalfBit.
  - Data bit n (0..7) sampled at t+HalfBit+(n+1)*ClocksPerBit.
  - Stop bit sampled at t+HalfBit+9*ClocksPerBit.
  - rx_valid_o rises on the cycle after the stop-bit sample.
  - From an rx_i transition, add 2 cycles of synchroniser latency.
- Back-to-back frames: the FSM is in IDLE from the cycle after the stop-bit sample, so a start edge arriving half a bit later is caught. No minimum idle time is required.
- FIFO: first-word fall-through; rx_data_o is valid combinationally from the head register.
  - Pop and push in the same cycle while full: pop first, push accepted, level unchanged, no overrun.
  - Pop and push in the same cycle while empty: the push lands, and rx_valid_o rises on the next cycle.
  - rx_ready_i while empty is ignored.
  - Read and write pointers wrap modulo FifoDepth.
- Reset asserted mid-frame: the FSM goes to IDLE, the FIFO empties, and all outputs return to reset values immediately (async). After release, a frame already in progress resynchronises on the next falling edge. Garbage may be received once; no hang is allowed.
- frame_err_o and overrun_o are never asserted in the same cycle.

Decomposition:
- uart_pkg holds:
  - enum uart_rx_state_e {IDLE, START, DATA, STOP, BREAK};
  - localparam UartDataWidth = 8;
  - a shared ClocksPerBit helper function, also used by the TX block.
- Sub-module uart_rx_fifo (parameters Width, Depth): synchronous FIFO with push/pop/full/empty/level. The top level holds the synchroniser, bit timer and FSM.

Test Plan:
Bench settings: ClockFrequency=1_600_000, BaudRate=100_000 (ClocksPerBit=16), FifoDepth=4.
- Single byte 0xA5, rx_ready_i=1 -> rx_valid_o high for exactly 1 cycle with rx_data_o=0xA5, at 2+8+144+1 cycles after the rx_i fall. No error pulses.
- Low glitch of 5 cycles on rx_i -> no byte, no frame_err_o, rx_busy_o returns to 0 after the start check.
- Frame 0x3C with stop bit driven 0, then line held low for 40 cycles, then 0x55 -> one frame_err_o pulse; 0x3C not delivered; 0x55 received correctly.
- Five back-to-back bytes 0x01..0x05 with rx_ready_i=0 -> rx_level_o reaches 4; one overrun_o pulse at the 5th stop bit. Then raising rx_ready_i drains 0x01..0x04 in order.
- FIFO full, and rx_ready_i pulsed on the exact cycle of a stop-bit push -> no overrun, rx_level_o stays 4, head advances.
- rst_ni asserted during data bit 4 of a frame -> all outputs at reset values immediately. After release, the next clean frame 0x7E is received correctly.
